axis_xfer_sequencer: RTL and testbench

- Sequences length-framed transfers through the FIFO-to-AXI-Stream adapter.
- Accepts a command carrying a beat count and gates the producer so it writes exactly that many beats.
- Pulses the adapter's CTRL_ALLOW after the final beat, then waits for CTRL_FINISHED before reporting completion.
- Sits between the accelerator's command/status logic and the adapter's control port, on the accelerator clock.

---
 rtl/axis_xfer_sequencer_if.sv | 29 ++
 rtl/axis_xfer_sequencer.sv | 123 ++++++++++++
 tb/tb_axis_xfer_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_xfer_sequencer_if.sv
// rtl/axis_xfer_sequencer_if.sv - command, producer-gate and adapter-control signals of the transfer sequencer
interface axis_xfer_sequencer_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [LEN_WIDTH-1:0] CMD_LEN;
    logic                 SRC_ENABLE;
    logic                 SRC_WRITE;
    logic                 SRC_FULL;
    logic                 CTRL_ALLOW;
    logic                 CTRL_FINISHED;
    logic                 BUSY;
    logic                 DONE;
    logic                 ERR;
    logic [LEN_WIDTH-1:0] BEAT_COUNT;

    // Sequencer side
    modport master (
        input  CMD_VALID, CMD_LEN, SRC_WRITE, SRC_FULL, CTRL_FINISHED,
        output CMD_READY, SRC_ENABLE, CTRL_ALLOW, BUSY, DONE, ERR, BEAT_COUNT
    );

    // Command/producer/adapter side
    modport slave (
        output CMD_VALID, CMD_LEN, SRC_WRITE, SRC_FULL, CTRL_FINISHED,
        input  CMD_READY, SRC_ENABLE, CTRL_ALLOW, BUSY, DONE, ERR, BEAT_COUNT
    );
endinterface

// File: rtl/axis_xfer_sequencer.sv
// rtl/axis_xfer_sequencer.sv - length-framed transfer sequencer in front of the FIFO-to-AXI-Stream adapter
module axis_xfer_sequencer #(
    parameter int LEN_WIDTH      = 16,
    parameter bit FULL_ACTIVE    = 1'b0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    ACC_CLK,
    input  logic                    ARESETN,
    axis_xfer_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAST,
        DRAIN,
        DONE_ST
    } state_t;

    localparam bit          WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] WD_LIMIT = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 err_q, err_d;
    logic [31:0]          wd_q, wd_d;

    logic full;
    logic src_enable;
    logic cmd_ready;
    logic acc;
    logic wd_hit;

    // Producer gating is a pure function of state so the enable drops in the
    // same cycle the final beat moves the FSM into LAST.
    assign full       = FULL_ACTIVE ? bus.SRC_FULL : ~bus.SRC_FULL;
    assign src_enable = (state_q == RUN);
    assign cmd_ready  = (state_q == IDLE) & ARESETN;
    assign acc        = bus.SRC_WRITE & src_enable & ~full;
    assign wd_hit     = WD_EN && (wd_q == WD_LIMIT);

    assign bus.CMD_READY  = cmd_ready;
    assign bus.SRC_ENABLE = src_enable;
    assign bus.CTRL_ALLOW = (state_q == LAST) && (len_q != '0);
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.DONE       = (state_q == DONE_ST);
    assign bus.ERR        = err_q;
    assign bus.BEAT_COUNT = count_q;

    // Next-state, beat counting, error capture and stall watchdog
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        err_d   = err_q;
        wd_d    = wd_q;

        case (state_q)
            IDLE: begin
                if (bus.CMD_VALID && cmd_ready) begin
                    len_d   = bus.CMD_LEN;
                    count_d = '0;
                    err_d   = (bus.CMD_LEN == '0);
                    state_d = (bus.CMD_LEN == '0) ? LAST : RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    count_d = count_q + LEN_WIDTH'(1);
                    if (count_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = LAST;
                    end
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = LAST;
                end
            end
            LAST: begin
                // A zero-length command never opens a frame, so nothing to flush.
                state_d = (len_q == '0) ? DONE_ST : DRAIN;
            end
            DRAIN: begin
                if (bus.CTRL_FINISHED) begin
                    state_d = DONE_ST;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Idle counter restarts on any accepted beat or state change.
        if (!WD_EN || acc || (state_d != state_q) ||
            !((state_q == RUN) || (state_q == DRAIN))) begin
            wd_d = 32'd0;
        end else begin
            wd_d = wd_q + 32'd1;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge ACC_CLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_axis_xfer_sequencer.sv
// tb/tb_axis_xfer_sequencer.sv - scoreboard bench for axis_xfer_sequencer
module tb_axis_xfer_sequencer;
    localparam int LW = 16;
    localparam int EV_ACC   = 0;
    localparam int EV_ALLOW = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int            kind;
        int            cyc;
        logic          err;
        logic [LW-1:0] beats;
    } ev_t;

    logic ACC_CLK = 1'b0;
    logic ARESETN = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    ev_t  exp_q[$];

    axis_xfer_sequencer_if #(.LEN_WIDTH(LW)) bus ();

    axis_xfer_sequencer #(
        .LEN_WIDTH(LW),
        .FULL_ACTIVE(1'b0),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ACC_CLK(ACC_CLK),
        .ARESETN(ARESETN),
        .bus(bus)
    );

    always #5 ACC_CLK = ~ACC_CLK;

    // cycle n is the interval following the n-th rising edge
    always @(posedge ACC_CLK) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_ACC:   return "accept";
            EV_ALLOW: return "allow";
            default:  return "done";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c, input logic err, input logic [LW-1:0] beats);
        ev_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.err   = err;
        e.beats = beats;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: actual %s at cycle %0d, required none", kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_DONE && (bus.ERR !== e.err || bus.BEAT_COUNT !== e.beats))) begin
                n_bad++;
                $display("FAIL event: actual %s cyc=%0d err=%0b beats=%0d, required %s cyc=%0d err=%0b beats=%0d",
                         kname(kind), cyc, bus.ERR, bus.BEAT_COUNT,
                         kname(e.kind), e.cyc, e.err, e.beats);
            end
        end
    endtask

    // Monitor: every DUT-visible event is matched against the scoreboard queue
    always @(negedge ACC_CLK) begin
        if (bus.SRC_ENABLE === 1'b1 && bus.SRC_WRITE === 1'b1 && bus.SRC_FULL === 1'b1) check_ev(EV_ACC);
        if (bus.CTRL_ALLOW === 1'b1) check_ev(EV_ALLOW);
        if (bus.DONE === 1'b1) check_ev(EV_DONE);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge ACC_CLK);
            #1;
        end
    endtask

    // Holds CMD_VALID until the handshake; returns the handshake cycle.
    task automatic issue_cmd(input logic [LW-1:0] len, output int hs);
        bit got;
        got = 1'b0;
        bus.CMD_LEN   = len;
        bus.CMD_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACC_CLK);
            if (bus.CMD_READY === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("cmd_handshake_in_budget", 32'(got), 32'd1);
        hs = cyc;
        @(posedge ACC_CLK);
        #1;
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic pulse_fin(input int n);
        goto_cycle(n);
        bus.CTRL_FINISHED = 1'b1;
        @(posedge ACC_CLK);
        #1;
        bus.CTRL_FINISHED = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.CMD_READY), 32'd0);
        chk({tag, "_src_enable"}, 32'(bus.SRC_ENABLE), 32'd0);
        chk({tag, "_ctrl_allow"}, 32'(bus.CTRL_ALLOW), 32'd0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_done"}, 32'(bus.DONE), 32'd0);
        chk({tag, "_err"}, 32'(bus.ERR), 32'd0);
        chk({tag, "_beat_count"}, 32'(bus.BEAT_COUNT), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: actual still running at cycle %0d, required finished", cyc);
        $fatal(1);
    end

    initial begin
        int hs, hs2;
        bus.CMD_VALID     = 1'b0;
        bus.CMD_LEN       = '0;
        bus.SRC_WRITE     = 1'b0;
        bus.SRC_FULL      = 1'b1;
        bus.CTRL_FINISHED = 1'b0;

        // Reset state
        repeat (3) @(posedge ACC_CLK);
        @(negedge ACC_CLK);
        chk_reset_outputs("reset");
        @(posedge ACC_CLK);
        #1;
        ARESETN = 1'b1;

        // len=4, writer always on, never full
        bus.SRC_WRITE = 1'b1;
        issue_cmd(16'd4, hs);
        for (int i = 1; i <= 4; i++) push_ev(EV_ACC, hs + i, 1'b0, '0);
        push_ev(EV_ALLOW, hs + 5, 1'b0, '0);
        push_ev(EV_DONE, hs + 8, 1'b0, 16'd4);
        pulse_fin(hs + 7);
        @(negedge ACC_CLK);
        chk("t1_busy_during_done", 32'(bus.BUSY), 32'd1);
        @(posedge ACC_CLK);
        #1;
        @(negedge ACC_CLK);
        chk("t1_busy_after_done", 32'(bus.BUSY), 32'd0);
        chk("t1_ready_after_done", 32'(bus.CMD_READY), 32'd1);
        @(posedge ACC_CLK);
        #1;

        // len=3, FIFO full on every other cycle
        issue_cmd(16'd3, hs);
        push_ev(EV_ACC, hs + 1, 1'b0, '0);
        push_ev(EV_ACC, hs + 3, 1'b0, '0);
        push_ev(EV_ACC, hs + 5, 1'b0, '0);
        push_ev(EV_ALLOW, hs + 6, 1'b0, '0);
        push_ev(EV_DONE, hs + 8, 1'b0, 16'd3);
        for (int c = hs + 2; c <= hs + 6; c++) begin
            goto_cycle(c);
            bus.SRC_FULL = ((c - hs) % 2 == 1);
        end
        bus.SRC_FULL = 1'b1;
        pulse_fin(hs + 7);
        goto_cycle(hs + 10);

        // len=0: no enable, no allow, error completion
        issue_cmd(16'd0, hs);
        push_ev(EV_DONE, hs + 2, 1'b1, 16'd0);
        goto_cycle(hs + 6);

        // len=5, producer stalls after 2 beats: eight idle cycles, then flush
        issue_cmd(16'd5, hs);
        push_ev(EV_ACC, hs + 1, 1'b0, '0);
        push_ev(EV_ACC, hs + 2, 1'b0, '0);
        push_ev(EV_ALLOW, hs + 11, 1'b0, '0);
        push_ev(EV_DONE, hs + 14, 1'b1, 16'd2);
        goto_cycle(hs + 3);
        bus.SRC_WRITE = 1'b0;
        pulse_fin(hs + 13);
        goto_cycle(hs + 16);

        // Reset after beat 2 of 6, then a normal len=1 transfer
        bus.SRC_WRITE = 1'b1;
        issue_cmd(16'd6, hs);
        push_ev(EV_ACC, hs + 1, 1'b0, '0);
        push_ev(EV_ACC, hs + 2, 1'b0, '0);
        goto_cycle(hs + 2);
        ARESETN = 1'b0;
        @(posedge ACC_CLK);
        #1;
        @(negedge ACC_CLK);
        chk_reset_outputs("midrun_reset");
        @(posedge ACC_CLK);
        #1;
        ARESETN = 1'b1;
        issue_cmd(16'd1, hs2);
        chk("post_reset_handshake_cycle", 32'(hs2), 32'(hs + 4));
        push_ev(EV_ACC, hs2 + 1, 1'b0, '0);
        push_ev(EV_ALLOW, hs2 + 2, 1'b0, '0);
        push_ev(EV_DONE, hs2 + 4, 1'b0, 16'd1);
        pulse_fin(hs2 + 3);
        goto_cycle(hs2 + 6);

        // Second command held while busy is taken the cycle after DONE
        issue_cmd(16'd2, hs);
        push_ev(EV_ACC, hs + 1, 1'b0, '0);
        push_ev(EV_ACC, hs + 2, 1'b0, '0);
        push_ev(EV_ALLOW, hs + 3, 1'b0, '0);
        push_ev(EV_DONE, hs + 5, 1'b0, 16'd2);
        fork
            issue_cmd(16'd3, hs2);
            pulse_fin(hs + 4);
        join
        chk("queued_cmd_handshake_cycle", 32'(hs2), 32'(hs + 6));
        for (int i = 1; i <= 3; i++) push_ev(EV_ACC, hs2 + i, 1'b0, '0);
        push_ev(EV_ALLOW, hs2 + 4, 1'b0, '0);
        push_ev(EV_DONE, hs2 + 6, 1'b0, 16'd3);
        pulse_fin(hs2 + 5);
        bus.SRC_WRITE = 1'b0;
        goto_cycle(hs2 + 10);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
